prom_arbiter: RTL and testbench
===============================

// Module: prom_arbiter
// PURPOSE
//   Shares one synchronous-read boot PROM (512 x 32, 1-cycle registered read)
//   between two requesters. Port A is the CPU boot/instruction fetch; port B is
//   an auxiliary reader, e.g. a monitor/debug readback or a boot-copy engine.
//   The block arbitrates per cycle, drives the PROM address, tracks each
//   in-flight read and returns the word to its owner through a registered
//   response stage.
// PARAMETERS
//   ADR_W    9   PROM address width (word addresses)
//   DATA_W   32  PROM data width
//   PRIO_A   0   0: round-robin on conflict; 1: A always wins, B gets idle cycles only
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst        in   1       reset, asynchronous, active-high
//   a_req      in   1       A read request; held with a_adr stable until a_ack
//   a_adr      in   ADR_W   A word address
//   a_ack      out  1       A request accepted this cycle (combinational)
//   a_rvalid   out  1       A read data valid, 1-cycle pulse per accepted request
//   a_rdata    out  DATA_W  A read data, holds last A word until next A return
//   b_req      in   1       B read request (same rules as A)
//   b_adr      in   ADR_W   B word address
//   b_ack      out  1       B request accepted this cycle
//   b_rvalid   out  1       B read data valid pulse
//   b_rdata    out  DATA_W  B read data, holds last B word
//   prom_adr   out  ADR_W   address to PROM (combinational from the winner)
//   prom_data  in   DATA_W  PROM registered read data (valid 1 cycle after address)
// BEHAVIOUR
//   Reset: a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, pipeline tags cleared,
//     last-grant pointer = B (A wins the first tie). a_ack/b_ack are 0 during rst.
//   Arbitration (cycle N, combinational): only A requests -> grant A; only B
//     -> grant B; both -> PRIO_A=1: A; PRIO_A=0: the port not granted last.
//     The last-grant pointer updates only on a grant; idle cycles keep it.
//   prom_adr = winner's address; with no request prom_adr = a_adr (harmless read).
//   At most one ack per cycle. Accepted requests give one read per cycle.
//   Pipeline: grant in N -> tag registered at end of N; PROM data valid in N+1
//     -> captured into owner's rdata register at end of N+1 -> x_rvalid high in
//     N+2 only. Fixed latency 2 from ack to rvalid; responses return in grant order.
//   Back-to-back grants to the same port give consecutive rvalid cycles.
//   Interleaved grants never cross data: the tag alone selects the destination
//     register; the other port's rdata is left unchanged.
//   A requester dropping req before ack: nothing is issued; no penalty.
//   Reset mid-operation (asynchronous): in-flight tags are discarded and no
//     rvalid follows rst release for reads acked before rst. rdata goes to 0.
//   No back-pressure on responses: requesters must sink a word on every rvalid.
// TESTING
//   1 rst=1 with both req=1 -> a_ack=b_ack=0, rvalids 0, rdatas 0; release ->
//     A granted first.
//   2 A alone, a_adr=0x005 at cycle N -> a_ack@N, prom_adr=0x005,
//     a_rvalid@N+2 with a_rdata=mem[5]; b_rvalid stays 0, b_rdata unchanged.
//   3 PRIO_A=0, a_req=b_req=1 held (a_adr=0x010, b_adr=0x020) -> acks A,B,A,B,...;
//     each rvalid exactly 2 cycles after its ack with mem[0x10]/mem[0x20].
//   4 PRIO_A=1, both held for 6 cycles -> b_ack never high; a_req drops at
//     cycle 6 -> b_ack@6, b_rvalid@8.
//   5 A streams adr 0..3 on consecutive cycles -> a_rvalid on 4 consecutive
//     cycles, data mem[0]..mem[3] in order.
//   6 a_ack at N, rst pulsed during N+1 -> no a_rvalid after release;
//     a_rdata=0 until next accepted read.

Source files
------------

// File: rtl/prom_arbiter.sv
// Two-port arbiter in front of a 1-cycle registered-read boot PROM.
// Grants one read per cycle and returns each word to its owner two cycles after ack.
module prom_arbiter #(
  parameter int unsigned ADR_W  = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PRIO_A = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADR_W-1:0]  a_adr,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADR_W-1:0]  b_adr,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADR_W-1:0]  prom_adr,
  input  logic [DATA_W-1:0] prom_data
);

  typedef enum logic {LAST_A, LAST_B} last_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B} tag_e;

  last_e             last_q, last_d;
  tag_e              tag_q, tag_d;
  tag_e              win;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= LAST_B;
      tag_q      <= TAG_NONE;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_q     <= last_d;
      tag_q      <= tag_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Winner is gated by rst so no ack can be issued while the pipeline is held clear.
  always_comb begin
    win = TAG_NONE;
    if (!rst) begin
      if (a_req && (!b_req || (PRIO_A != 0) || (last_q == LAST_B)))
        win = TAG_A;
      else if (b_req)
        win = TAG_B;
    end
  end

  always_comb begin
    last_d     = last_q;
    tag_d      = win;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    if (win == TAG_A) last_d = LAST_A;
    if (win == TAG_B) last_d = LAST_B;
    // The tag of the read issued last cycle alone picks the destination register.
    if (tag_q == TAG_A) begin
      a_rvalid_d = 1'b1;
      a_rdata_d  = prom_data;
    end
    if (tag_q == TAG_B) begin
      b_rvalid_d = 1'b1;
      b_rdata_d  = prom_data;
    end
  end

  always_comb begin
    a_ack    = (win == TAG_A);
    b_ack    = (win == TAG_B);
    prom_adr = (win == TAG_B) ? b_adr : a_adr;
    a_rvalid = a_rvalid_q;
    b_rvalid = b_rvalid_q;
    a_rdata  = a_rdata_q;
    b_rdata  = b_rdata_q;
  end

endmodule

// File: tb/tb_prom_arbiter.sv
// Randomized bench for prom_arbiter: round-robin and A-priority instances, each
// with its own PROM and requesters, compared against a grant-order latency model.
module tb_prom_arbiter;
  localparam int ADR_W  = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_req[2], b_req[2], a_ack[2], b_ack[2];
  logic              a_rvalid[2], b_rvalid[2];
  logic [ADR_W-1:0]  a_adr[2], b_adr[2], prom_adr[2];
  logic [DATA_W-1:0] a_rdata[2], b_rdata[2], prom_data[2];
  logic [DATA_W-1:0] mem [512];

  int n_chk  = 0;
  int n_pass = 0;

  // model state: g1/g2 = grant one / two cycles ago (0 none, 1 A, 2 B)
  int                last_m[2];
  int                g1[2], g2[2];
  logic [ADR_W-1:0]  g1adr[2], g2adr[2];
  logic [DATA_W-1:0] erd_a[2], erd_b[2];
  bit                acked_a[2], acked_b[2];
  int                rst_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    prom_data[0] <= mem[prom_adr[0]];
    prom_data[1] <= mem[prom_adr[1]];
  end

  prom_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W), .PRIO_A(0)) u_rr (
    .clk(clk), .rst(rst),
    .a_req(a_req[0]), .a_adr(a_adr[0]), .a_ack(a_ack[0]),
    .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req[0]), .b_adr(b_adr[0]), .b_ack(b_ack[0]),
    .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
    .prom_adr(prom_adr[0]), .prom_data(prom_data[0])
  );

  prom_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W), .PRIO_A(1)) u_pa (
    .clk(clk), .rst(rst),
    .a_req(a_req[1]), .a_adr(a_adr[1]), .a_ack(a_ack[1]),
    .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req[1]), .b_adr(b_adr[1]), .b_ack(b_ack[1]),
    .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
    .prom_adr(prom_adr[1]), .prom_data(prom_data[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset(input int k);
    last_m[k]  = 2;
    g1[k]      = 0;
    g2[k]      = 0;
    g1adr[k]   = '0;
    g2adr[k]   = '0;
    erd_a[k]   = '0;
    erd_b[k]   = '0;
    acked_a[k] = 1'b0;
    acked_b[k] = 1'b0;
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < 2; k++) begin
      if (!a_req[k] || acked_a[k]) begin
        a_req[k] = ($urandom_range(3) != 0);
        a_adr[k] = ADR_W'($urandom_range(511));
      end else if ($urandom_range(31) == 0) begin
        a_req[k] = 1'b0;
      end
      if (!b_req[k] || acked_b[k]) begin
        b_req[k] = ($urandom_range(3) != 0);
        b_adr[k] = ADR_W'($urandom_range(511));
      end else if ($urandom_range(31) == 0) begin
        b_req[k] = 1'b0;
      end
    end
  endtask

  task automatic evaluate();
    int win;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_reset(k);
        check($sformatf("k%0d rst a_ack", k), 32'(a_ack[k]), 0);
        check($sformatf("k%0d rst b_ack", k), 32'(b_ack[k]), 0);
        check($sformatf("k%0d rst a_rvalid", k), 32'(a_rvalid[k]), 0);
        check($sformatf("k%0d rst b_rvalid", k), 32'(b_rvalid[k]), 0);
        check($sformatf("k%0d rst a_rdata", k), a_rdata[k], 0);
        check($sformatf("k%0d rst b_rdata", k), b_rdata[k], 0);
      end else begin
        if (g2[k] == 1) erd_a[k] = mem[g2adr[k]];
        if (g2[k] == 2) erd_b[k] = mem[g2adr[k]];
        check($sformatf("k%0d a_rvalid", k), 32'(a_rvalid[k]), 32'(g2[k] == 1));
        check($sformatf("k%0d b_rvalid", k), 32'(b_rvalid[k]), 32'(g2[k] == 2));
        check($sformatf("k%0d a_rdata", k), a_rdata[k], erd_a[k]);
        check($sformatf("k%0d b_rdata", k), b_rdata[k], erd_b[k]);
        if (a_req[k] && b_req[k])
          win = (k == 1) ? 1 : ((last_m[k] == 1) ? 2 : 1);
        else if (a_req[k])
          win = 1;
        else if (b_req[k])
          win = 2;
        else
          win = 0;
        check($sformatf("k%0d a_ack", k), 32'(a_ack[k]), 32'(win == 1));
        check($sformatf("k%0d b_ack", k), 32'(b_ack[k]), 32'(win == 2));
        check($sformatf("k%0d prom_adr", k), 32'(prom_adr[k]),
              32'((win == 2) ? b_adr[k] : a_adr[k]));
        acked_a[k] = (win == 1);
        acked_b[k] = (win == 2);
        g2[k]      = g1[k];
        g2adr[k]   = g1adr[k];
        g1[k]      = win;
        g1adr[k]   = (win == 2) ? b_adr[k] : a_adr[k];
        if (win != 0) last_m[k] = win;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_req[k] = 1'b1;
      b_req[k] = 1'b1;
      a_adr[k] = 9'h010;
      b_adr[k] = 9'h020;
      model_reset(k);
    end
    rst_cnt = 3;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        rst = 1'b1;
      end else begin
        rst = 1'b0;
        if ($urandom_range(79) == 0) rst_cnt = 1 + $urandom_range(1);
      end
      if (cyc > 2) drive_reqs();
      @(negedge clk);
      evaluate();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
